mdu_sequencer: RTL and testbench

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts the decoded `MDUOp`, `MTHILO` and `MFHILO` controls, and owns the HI/LO register pair. It runs multi-cycle multiply and divide operations with a countdown state machine and generates the D-stage stall that keeps later HI/LO users from issuing while an operation is in flight. `MFHI`, `MFLO` and `MUL` read their E-stage result from this block.

---
 rtl/mdu_sequencer.sv | 156 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: HI/LO owner and multi-cycle multiply/divide sequencer for the E stage.
// Latency: the target value is latched at start and committed to {HI,LO} MULT_CYCLES/DIV_CYCLES edges later.
// Backpressure: Stall = D_MDUse & (Busy | Start), which holds later HI/LO users in D until the commit.
// Ports: clk/reset (sync, active-high); MDUOp/MTHILO/MFHILO E-stage controls; A/B operands;
//        ExcFlush cancels the E-stage instruction; D_MDUse flags a D-stage HI/LO user;
//        Busy/Stall status; Result = selected HI or LO (0 if none); HI/LO architectural values.
// Optional feature: define MDU_MADD_EN to implement MADD/MADDU/MSUB/MSUBU (codes 5-8).
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [1:0]  MTHILO,
    input  logic [1:0]  MFHILO,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ExcFlush,
    input  logic        D_MDUse,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Result,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [63:0]   pend, pend_nx;
    logic [31:0]   hi_nx, lo_nx;
    logic          is_mul, is_div, start;
    logic [63:0]   prod_s, prod_u, target;
    logic [31:0]   quo, rem;

    // Operation decode; codes outside the implemented set act as DUM.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (MDUOp)
            4'd1, 4'd2: is_mul = 1'b1;
            4'd3, 4'd4: is_div = 1'b1;
`ifdef MDU_MADD_EN
            4'd5, 4'd6, 4'd7, 4'd8: is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    // The low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divide: zero divisor and the signed overflow case have fixed architectural results.
    always_comb begin
        quo = '0;
        rem = '0;
        if (B == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = A;
        end else if (MDUOp == 4'd3) begin
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = 32'd0;
            end else begin
                quo = $signed(A) / $signed(B);
                rem = $signed(A) % $signed(B);
            end
        end else begin
            quo = A / B;
            rem = A % B;
        end
    end

    always_comb begin
        target = prod_u;
        case (MDUOp)
            4'd1:       target = prod_s;
            4'd2:       target = prod_u;
            4'd3, 4'd4: target = {rem, quo};
`ifdef MDU_MADD_EN
            4'd5:       target = {HI, LO} + prod_s;
            4'd6:       target = {HI, LO} + prod_u;
            4'd7:       target = {HI, LO} - prod_s;
            4'd8:       target = {HI, LO} - prod_u;
`endif
            default:    target = prod_u;
        endcase
    end

    assign start = (state == IDLE) && (is_mul || is_div) && !ExcFlush;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        hi_nx    = HI;
        lo_nx    = LO;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = is_div ? DIV_RUN : MUL_RUN;
                    cnt_nx   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    pend_nx  = target;
                end
                // MT writes only land when idle; the D-stage stall keeps them out while busy.
                if (!ExcFlush) begin
                    if (MTHILO == 2'b01)      lo_nx = A;
                    else if (MTHILO == 2'b11) hi_nx = A;
                end
            end
            default: begin
                // Both run states count down identically; commit on the last busy cycle.
                if (cnt <= CW'(1)) begin
                    {hi_nx, lo_nx} = pend;
                    cnt_nx         = '0;
                    state_nx       = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            HI    <= hi_nx;
            LO    <= lo_nx;
        end
    end

    assign Busy  = (state != IDLE);
    assign Stall = D_MDUse & (Busy | start);

    always_comb begin
        case (MFHILO)
            2'b01:   Result = LO;
            2'b10:   Result = HI;
            default: Result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [1:0]  MTHILO, MFHILO;
    logic [31:0] A, B;
    logic        ExcFlush, D_MDUse;
    logic        Busy, Stall;
    logic [31:0] Result, HI, LO;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .MTHILO(MTHILO), .MFHILO(MFHILO),
        .A(A), .B(B), .ExcFlush(ExcFlush), .D_MDUse(D_MDUse),
        .Busy(Busy), .Stall(Stall), .Result(Result), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit op_valid(input int op);
        return (op >= 1 && op <= 4) || (MADD_EN && op >= 5 && op <= 8);
    endfunction

    // Reference result from the architectural definition, in 64-bit integer arithmetic.
    function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] hl);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] ps, pu, qv, rv;
        longint      qa, q, r;
        ps = sa * sb;
        pu = ua * ub;
        case (op)
            1: return ps;
            2: return pu;
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
                r  = sa - q * sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                qv = ua / ub;
                rv = ua % ub;
                return {rv[31:0], qv[31:0]};
            end
            5: return hl + ps;
            6: return hl + pu;
            7: return hl - ps;
            8: return hl - pu;
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle,
    // so consecutive calls issue back-to-back.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic flush, input string tag);
        logic [63:0] exp;
        bit          v;
        int          n, busy_n, stall_n;
        v       = op_valid(op) && !flush;
        exp     = v ? model(op, a, b, {m_hi, m_lo}) : {m_hi, m_lo};
        n       = v ? ((op == 3 || op == 4) ? 10 : 5) : 0;
        busy_n  = 0;
        stall_n = 0;
        MDUOp = op[3:0]; A = a; B = b; ExcFlush = flush;
        MTHILO = 2'b00; MFHILO = 2'b00; D_MDUse = 1'b1;
        #1;
        chk({tag, "_start_stall"}, {63'd0, Stall}, {63'd0, v});
        if (Stall) stall_n++;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (!Busy) break;
            busy_n++;
            // Inputs while busy must be ignored.
            MDUOp = 4'($urandom); A = $urandom; B = $urandom;
            MTHILO = 2'($urandom); ExcFlush = 1'($urandom);
            #1;
            if (Stall) stall_n++;
        end
        MDUOp = 4'd0; ExcFlush = 1'b0; MTHILO = 2'b00; D_MDUse = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(n));
        chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(v ? n + 1 : 0));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk({tag, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
        MFHILO = 2'b01; #1;
        chk({tag, "_mflo"}, {32'd0, Result}, {32'd0, m_lo});
        MFHILO = 2'b10; #1;
        chk({tag, "_mfhi"}, {32'd0, Result}, {32'd0, m_hi});
        MFHILO = 2'b00;
    endtask

    task automatic mt(input logic hi_sel, input logic [31:0] val, input logic flush, input string tag);
        MTHILO = hi_sel ? 2'b11 : 2'b01; A = val; ExcFlush = flush; MDUOp = 4'd0; D_MDUse = 1'b0;
        @(negedge clk);
        MTHILO = 2'b00; ExcFlush = 1'b0;
        if (!flush) begin
            if (hi_sel) m_hi = val;
            else        m_lo = val;
        end
        chk({tag, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
    endtask

    initial begin
        reset = 1'b1; MDUOp = 4'd0; MTHILO = 2'b00; MFHILO = 2'b01;
        A = 32'd0; B = 32'd0; ExcFlush = 1'b0; D_MDUse = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_stall", {63'd0, Stall}, 64'd0);
        chk("reset_result_lo", {32'd0, Result}, 64'd0);
        MFHILO = 2'b10; #1;
        chk("reset_result_hi", {32'd0, Result}, 64'd0);
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        MFHILO = 2'b00; D_MDUse = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
        chk("mult_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFA);
        chk("mult_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        chk("div_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        run_op(4, 32'd7, 32'd0, 1'b0, "divu_by0");
        chk("divu0_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFF);
        chk("divu0_hi_const", {32'd0, HI}, 64'd7);
        run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(3, 32'hFFFF_FF00, 32'd0, 1'b0, "div_by0");
        mt(1'b1, 32'h1234, 1'b0, "mthi");
        mt(1'b0, 32'h5678, 1'b0, "mtlo");
        run_op(6, 32'h1_0000, 32'h1_0000, 1'b0, "maddu");
        chk("maddu_hi_const", {32'd0, HI}, MADD_EN ? 64'h1235 : 64'h1234);
        chk("maddu_lo_const", {32'd0, LO}, 64'h5678);
        run_op(1, 32'd11, 32'd13, 1'b1, "mult_flushed");
        mt(1'b0, 32'hDEAD_BEEF, 1'b1, "mtlo_flushed");

        // Reset at the third busy cycle of a DIV discards the pending result.
        MDUOp = 4'd3; A = 32'd100; B = 32'd7; D_MDUse = 1'b0;
        repeat (3) @(negedge clk);
        MDUOp = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rstmid_busy", {63'd0, Busy}, 64'd0);
        chk("rstmid_hi", {32'd0, HI}, 64'd0);
        chk("rstmid_lo", {32'd0, LO}, 64'd0);
        repeat (12) @(negedge clk);
        chk("rstmid_late_hi", {32'd0, HI}, 64'd0);
        chk("rstmid_late_lo", {32'd0, LO}, 64'd0);

        // Randomised sequence, back-to-back
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0)
                mt(1'($urandom), pick(), ($urandom_range(0, 3) == 0), "rnd_mt");
            else
                run_op($urandom_range(0, 9), pick(), pick(), ($urandom_range(0, 7) == 0), "rnd_op");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
